// File: rtl/hwpe_ctrl_regfile_multictx.sv
// Multi-context register file: firmware fills the writer context while the engine
// reads the committed head context; contexts circulate as a queue of banks.
module hwpe_ctrl_regfile_multictx #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned NUM_WORDS   = 2**ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_BYTE    = DATA_WIDTH/8,
    parameter int unsigned NUM_CONTEXT = 2,
    parameter int unsigned NUM_RPORTS  = 2,
    parameter int unsigned CTX_W       = $clog2(NUM_CONTEXT)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             WriteEnable,
    input  logic [ADDR_WIDTH-1:0]            WriteAddr,
    input  logic [NUM_BYTE*8-1:0]            WriteData,
    input  logic [NUM_BYTE-1:0]              WriteBE,
    input  logic                             Commit,
    output logic                             WriteReady,
    input  logic [NUM_RPORTS-1:0]            ReadEnable,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] ReadAddr,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] ReadData,
    input  logic                             Release,
    output logic                             CtxValid,
    output logic [CTX_W:0]                   CtxCount,
    output logic [CTX_W-1:0]                 WriteCtxId,
    output logic [CTX_W-1:0]                 ReadCtxId,
    output logic [NUM_WORDS*DATA_WIDTH-1:0]  MemContent
);

    localparam int unsigned CNT_W = CTX_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [NUM_CONTEXT][NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_CONTEXT][NUM_WORDS];
    logic [CTX_W-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] be_mask;
    logic                  full, empty, waddr_ok, do_write, do_commit, do_release;

    // Pure modulo wrap so non-power-of-2 context counts work.
    function automatic logic [CTX_W-1:0] ptr_inc(input logic [CTX_W-1:0] p);
        return (p == CTX_W'(NUM_CONTEXT - 1)) ? '0 : p + CTX_W'(1);
    endfunction

    for (genvar j = 0; j < NUM_BYTE; j++) begin : g_be_mask
        assign be_mask[j*8 +: 8] = {8{WriteBE[j]}};
    end

    assign full       = (cnt_q == CNT_W'(NUM_CONTEXT));
    assign empty      = (cnt_q == '0);
    assign waddr_ok   = ({1'b0, WriteAddr} < (ADDR_WIDTH+1)'(NUM_WORDS));
    assign do_write   = WriteEnable && !full && waddr_ok;
    assign do_commit  = Commit && !full;
    assign do_release = Release && !empty;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (clear) begin
            mem_d = '{default: '0};
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_write) begin
                mem_d[wp_q][WriteAddr] = (mem_q[wp_q][WriteAddr] & ~be_mask) | (WriteData & be_mask);
            end
            // Releasing scrubs the head bank so the writer reuses a clean context.
            if (do_release) begin
                mem_d[rp_q] = '{default: '0};
                rp_d        = ptr_inc(rp_q);
            end
            if (do_commit) begin
                wp_d = ptr_inc(wp_q);
            end
            case ({do_commit, do_release})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        logic [ADDR_WIDTH-1:0] raddr;
        logic                  raddr_ok;
        logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

        assign raddr    = ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign raddr_ok = ({1'b0, raddr} < (ADDR_WIDTH+1)'(NUM_WORDS));

        always_comb begin
            rdata_d = rdata_q;
            if (clear) begin
                rdata_d = '0;
            end else if (ReadEnable[p]) begin
                rdata_d = raddr_ok ? mem_q[rp_q][raddr] : '0;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign ReadData[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_mem_content
        assign MemContent[w*DATA_WIDTH +: DATA_WIDTH] = mem_q[rp_q][w];
    end

    assign WriteReady = !full;
    assign CtxValid   = !empty;
    assign CtxCount   = cnt_q;
    assign WriteCtxId = wp_q;
    assign ReadCtxId  = rp_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_multictx.sv
// Bench for hwpe_ctrl_regfile_multictx: directed steps followed by random traffic,
// all outputs compared every cycle against a queue-of-banks reference model.
module tb_hwpe_ctrl_regfile_multictx;

    localparam int unsigned AW = 5;
    localparam int unsigned NW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW/8;
    localparam int unsigned NC = 3;
    localparam int unsigned NR = 2;
    localparam int unsigned CW = $clog2(NC);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              WriteEnable;
    logic [AW-1:0]     WriteAddr;
    logic [DW-1:0]     WriteData;
    logic [NB-1:0]     WriteBE;
    logic              Commit;
    logic              WriteReady;
    logic [NR-1:0]     ReadEnable;
    logic [NR*AW-1:0]  ReadAddr;
    logic [NR*DW-1:0]  ReadData;
    logic              Release;
    logic              CtxValid;
    logic [CW:0]       CtxCount;
    logic [CW-1:0]     WriteCtxId;
    logic [CW-1:0]     ReadCtxId;
    logic [NW*DW-1:0]  MemContent;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m [NC][1<<AW];
    logic [DW-1:0] rd_m [NR];
    int wp_m, rp_m, cnt_m;

    hwpe_ctrl_regfile_multictx #(
        .ADDR_WIDTH(AW), .NUM_WORDS(NW), .DATA_WIDTH(DW), .NUM_BYTE(NB),
        .NUM_CONTEXT(NC), .NUM_RPORTS(NR), .CTX_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .WriteBE(WriteBE), .Commit(Commit), .WriteReady(WriteReady),
        .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData),
        .Release(Release), .CtxValid(CtxValid), .CtxCount(CtxCount),
        .WriteCtxId(WriteCtxId), .ReadCtxId(ReadCtxId), .MemContent(MemContent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: whole-bank queue semantics evaluated on pre-edge state.
    task automatic model_step();
        bit full, empty;
        int a;
        if (!rst_n || clear) begin
            for (int c = 0; c < NC; c++)
                for (int w = 0; w < (1<<AW); w++) m[c][w] = '0;
            for (int p = 0; p < NR; p++) rd_m[p] = '0;
            wp_m = 0; rp_m = 0; cnt_m = 0;
        end else begin
            full  = (cnt_m == NC);
            empty = (cnt_m == 0);
            for (int p = 0; p < NR; p++) begin
                if (ReadEnable[p]) begin
                    a = int'(ReadAddr[p*AW +: AW]);
                    rd_m[p] = (a < NW) ? m[rp_m][a] : '0;
                end
            end
            if (WriteEnable && !full && int'(WriteAddr) < NW) begin
                for (int j = 0; j < NB; j++)
                    if (WriteBE[j]) m[wp_m][WriteAddr][j*8 +: 8] = WriteData[j*8 +: 8];
            end
            if (Release && !empty) begin
                for (int w = 0; w < (1<<AW); w++) m[rp_m][w] = '0;
                rp_m  = (rp_m + 1) % NC;
                cnt_m = cnt_m - 1;
            end
            if (Commit && !full) begin
                wp_m  = (wp_m + 1) % NC;
                cnt_m = cnt_m + 1;
            end
        end
    endtask

    task automatic check_all();
        chk("WriteReady", 64'(WriteReady), 64'(cnt_m < NC));
        chk("CtxValid",   64'(CtxValid),   64'(cnt_m > 0));
        chk("CtxCount",   64'(CtxCount),   64'(cnt_m));
        chk("WriteCtxId", 64'(WriteCtxId), 64'(wp_m));
        chk("ReadCtxId",  64'(ReadCtxId),  64'(rp_m));
        for (int p = 0; p < NR; p++)
            chk($sformatf("ReadData[%0d]", p), 64'(ReadData[p*DW +: DW]), 64'(rd_m[p]));
        for (int w = 0; w < NW; w++)
            chk($sformatf("MemContent[%0d]", w), 64'(MemContent[w*DW +: DW]), 64'(m[rp_m][w]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        clear = 1'b0; WriteEnable = 1'b0; WriteAddr = '0; WriteData = '0; WriteBE = '0;
        Commit = 1'b0; Release = 1'b0; ReadEnable = '0; ReadAddr = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        WriteEnable = 1'b1; WriteAddr = AW'(a); WriteData = d; WriteBE = be;
    endtask

    task automatic rd_req(input int p, input int a);
        ReadEnable[p] = 1'b1;
        ReadAddr[p*AW +: AW] = AW'(a);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cycle();
        cycle();
        chk("reset_WriteReady", 64'(WriteReady), 64'd1);
        chk("reset_CtxCount", 64'(CtxCount), 64'd0);
        rst_n = 1'b1;

        idle(); wr(3, 32'hDEADBEEF, 4'hF); cycle();
        idle(); rd_req(0, 3); cycle();
        chk("rd_full_word", 64'(ReadData[DW-1:0]), 64'hDEADBEEF);
        chk("rd_ctxvalid", 64'(CtxValid), 64'd0);

        idle(); wr(3, 32'h11223344, 4'b0101); cycle();
        idle(); wr(NW, 32'hFFFFFFFF, 4'hF); cycle();
        idle(); rd_req(0, 3); rd_req(1, NW); cycle();
        chk("byte_merge", 64'(ReadData[DW-1:0]), 64'hDE22BE44);
        chk("oob_read", 64'(ReadData[2*DW-1:DW]), 64'd0);

        idle(); wr(0, 32'hA, 4'hF); rd_req(0, 0); Commit = 1'b1; cycle();
        chk("rw_hazard_old", 64'(ReadData[DW-1:0]), 64'd0);
        chk("commit_count", 64'(CtxCount), 64'd1);
        chk("commit_wp", 64'(WriteCtxId), 64'd1);

        idle(); wr(0, 32'hB, 4'hF); cycle();
        idle(); rd_req(0, 0); rd_req(1, 0); cycle();
        chk("head_p0", 64'(ReadData[DW-1:0]), 64'hA);
        chk("head_p1", 64'(ReadData[2*DW-1:DW]), 64'hA);

        idle(); Commit = 1'b1; cycle();
        idle(); wr(0, 32'hC, 4'hF); Commit = 1'b1; cycle();
        chk("full_count", 64'(CtxCount), 64'd3);
        chk("full_ready", 64'(WriteReady), 64'd0);

        idle(); wr(0, 32'hFF, 4'hF); cycle();
        chk("full_write_ignored", 64'(MemContent[DW-1:0]), 64'hA);

        idle(); wr(0, 32'hFF, 4'hF); Release = 1'b1; cycle();
        chk("release_rp", 64'(ReadCtxId), 64'd1);
        chk("release_ready", 64'(WriteReady), 64'd1);

        idle(); rd_req(0, 0); rd_req(1, 0); wr(1, 32'h5, 4'hF); cycle();
        chk("next_head_p0", 64'(ReadData[DW-1:0]), 64'hB);
        chk("next_head_p1", 64'(ReadData[2*DW-1:DW]), 64'hB);

        idle(); Release = 1'b1; rd_req(0, 0); cycle();
        chk("read_on_release", 64'(ReadData[DW-1:0]), 64'hB);
        chk("rp_two", 64'(ReadCtxId), 64'd2);

        idle(); Commit = 1'b1; Release = 1'b1; cycle();
        chk("cr_count", 64'(CtxCount), 64'd1);
        chk("cr_wp", 64'(WriteCtxId), 64'd1);
        chk("cr_rp_wrap", 64'(ReadCtxId), 64'd0);

        idle(); Release = 1'b1; cycle();
        idle(); Release = 1'b1; cycle();
        chk("empty_release_count", 64'(CtxCount), 64'd0);
        chk("empty_release_rp", 64'(ReadCtxId), 64'd1);

        idle(); Commit = 1'b1; cycle();
        idle(); Commit = 1'b1; cycle();
        idle(); Commit = 1'b1; clear = 1'b1; rd_req(0, 0); cycle();
        chk("clear_count", 64'(CtxCount), 64'd0);
        chk("clear_wp", 64'(WriteCtxId), 64'd0);
        chk("clear_rp", 64'(ReadCtxId), 64'd0);
        chk("clear_rd", 64'(ReadData[DW-1:0]), 64'd0);

        for (int i = 0; i < 400; i++) begin
            idle();
            WriteEnable = ($urandom_range(0, 3) != 0);
            WriteAddr   = AW'($urandom_range(0, 31));
            WriteData   = DW'($urandom);
            WriteBE     = NB'($urandom);
            Commit      = ($urandom_range(0, 3) == 0);
            Release     = ($urandom_range(0, 3) == 0);
            ReadEnable  = NR'($urandom);
            ReadAddr    = (NR*AW)'($urandom);
            clear       = ($urandom_range(0, 60) == 0);
            rst_n       = ($urandom_range(0, 80) != 0);
            cycle();
        end
        rst_n = 1'b1;

        idle(); wr(2, 32'h77, 4'hF); Commit = 1'b1; cycle();
        idle(); Commit = 1'b1; cycle();
        idle(); rst_n = 1'b0; Commit = 1'b1; Release = 1'b1; cycle();
        rst_n = 1'b1;
        chk("midq_reset_count", 64'(CtxCount), 64'd0);
        chk("midq_reset_valid", 64'(CtxValid), 64'd0);
        chk("midq_reset_mem", 64'(MemContent[3*DW-1:2*DW]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
